ifetch_queue: RTL and testbench



---
 rtl/ifetch_queue_pkg.sv | 20 ++
 rtl/ifetch_queue_if.sv | 31 +++
 rtl/ifetch_queue_fifo.sv | 64 ++++++
 rtl/ifetch_queue.sv | 90 +++++++++
 tb/tb_ifetch_queue.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_queue_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch front end.
//   ifetch_entry_t   : one prefetch queue entry {pc, word}
//   PC_STEP          : byte distance between consecutive instruction words
//   DEFAULT_RESET_PC : default first fetch address after reset
//   word_align()     : clears the byte-offset bits of an address
package ifetch_pkg;

    localparam int unsigned PC_STEP = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } ifetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: signal bundle between the fetch front end and its neighbours.
//   imem_req/imem_addr        : request to instruction memory (always accepted)
//   imem_rvalid/imem_rdata    : in-order response from instruction memory
//   redirect_valid/redirect_pc: one-cycle restart pulse from branch resolution
//   instr_valid/instr/instr_pc: queue head presented to decode
//   instr_ready               : decode accepts the head this cycle
// Modports: master = fetch front end, slave = memory/core side.
interface ifetch_queue_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/ifetch_queue_fifo.sv
// ifetch_fifo: synchronous FIFO of ifetch_entry_t used as the prefetch queue.
//   clk, rst        : clock, asynchronous active-high reset
//   clear           : synchronous flush, overrides push and pop
//   push, push_data : write an entry (accepted when not full, or full with pop)
//   pop             : drop the head entry (ignored when empty)
//   head            : current head entry (undefined content when empty)
//   count           : number of stored entries, 0..DEPTH
//   empty, full     : status flags derived from count
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  ifetch_entry_t push_data,
    input  logic          pop,
    output ifetch_entry_t head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    ifetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A full queue can still take a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (!clear && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch front end for the single-cycle RV32 core.
// Owns the fetch PC, issues in-order word requests under a credit limit of
// DEPTH (outstanding requests plus queued entries), buffers returned words
// with their PCs, and drops stale responses after a redirect.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ifetch_queue_if.master (memory request/response, redirect,
//              decode handshake)
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_queue_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic          credit_ok;
    logic          req;
    logic          keep;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;
    ifetch_entry_t head;
    ifetch_entry_t push_entry;

    // Credit uses registered state only, so imem_req has no path from
    // imem_rvalid or instr_ready.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, count}) < (CW + 1)'(DEPTH);
    assign req       = !rst && !bus.redirect_valid && credit_ok;

    assign keep       = bus.imem_rvalid && (drop_cnt == '0) && !bus.redirect_valid;
    assign push_entry = '{pc: resp_pc, word: bus.imem_rdata};
    assign pop        = bus.instr_valid && bus.instr_ready;

    assign bus.imem_req    = req;
    assign bus.imem_addr   = fetch_pc;
    assign bus.instr_valid = !fifo_empty;
    assign bus.instr       = fifo_empty ? '0 : head.word;
    assign bus.instr_pc    = fifo_empty ? '0 : head.pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc    <= word_align(bus.redirect_pc);
            resp_pc     <= word_align(bus.redirect_pc);
            outstanding <= outstanding - CW'(bus.imem_rvalid);
            // Responses already marked for dropping are a subset of the
            // outstanding ones, so every request still in flight (less the
            // one returning now) becomes stale; adding drop_cnt again would
            // double-count them on back-to-back redirects.
            drop_cnt    <= outstanding - CW'(bus.imem_rvalid);
        end else begin
            if (req) fetch_pc <= fetch_pc + PC_STEP;
            outstanding <= outstanding + CW'(req) - CW'(bus.imem_rvalid);
            if (bus.imem_rvalid) begin
                if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                else                resp_pc  <= resp_pc + PC_STEP;
            end
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.redirect_valid),
        .push      (keep),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: randomized self-checking bench for ifetch_queue.
// A memory model with selectable latency answers requests in order; a
// reference model tracks in-flight requests (with a stale mark set by
// redirects) and the expected instruction queue, and every cycle the DUT
// outputs are compared against it.
module tb_ifetch_queue;
    import ifetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned QDEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        bit          stale;
        int unsigned issue;
    } flight_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } qent_t;

    logic clk;
    logic rst;
    ifetch_queue_if bus ();

    ifetch_queue #(
        .RESET_PC (RST_PC),
        .DEPTH    (QDEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    flight_t     inflight[$];
    qent_t       expq[$];
    logic [31:0] model_pc;
    int unsigned cyc = 0;
    int unsigned lat = 1;
    int unsigned ready_pct = 100;
    logic        redir_now = 1'b0;
    logic [31:0] redir_tgt = '0;
    logic        rst_next = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        if (a == 32'h0) return 32'h0040_0093;
        if (a == 32'h4) return 32'h0020_d193;
        return a ^ 32'hA5A5_0013;
    endfunction

    function automatic bit resp_due();
        return inflight.size() > 0 && cyc >= inflight[0].issue + lat;
    endfunction

    // One clock cycle: drive inputs after the edge, check mid-cycle, then
    // advance the reference model to the state after the coming edge.
    task automatic tick();
        logic        exp_req;
        bit          do_pop;
        int unsigned stale_n;
        flight_t     f;
        @(posedge clk);
        #1;
        rst = rst_next;
        bus.instr_ready = ($urandom_range(99) < ready_pct);
        if (!rst && resp_due()) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = word_of(inflight[0].pc);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end
        bus.redirect_valid = !rst && redir_now;
        bus.redirect_pc    = redir_now ? redir_tgt : $urandom;
        redir_now = 1'b0;
        #3;
        if (rst) begin
            check_eq("rst_req",   {31'b0, bus.imem_req},    32'h0);
            check_eq("rst_addr",  bus.imem_addr,            RST_PC);
            check_eq("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
            check_eq("rst_instr", bus.instr,                32'h0);
            check_eq("rst_pc",    bus.instr_pc,             32'h0);
            inflight.delete();
            expq.delete();
            model_pc = RST_PC;
        end else begin
            exp_req = !bus.redirect_valid && (inflight.size() + expq.size() < QDEPTH);
            stale_n = 0;
            foreach (inflight[i]) if (inflight[i].stale) stale_n++;
            check_eq("req",   {31'b0, bus.imem_req},    {31'b0, exp_req});
            check_eq("addr",  bus.imem_addr,            model_pc);
            check_eq("valid", {31'b0, bus.instr_valid}, {31'b0, expq.size() > 0});
            check_eq("count", 32'(dut.count),           32'(expq.size()));
            check_eq("drop",  32'(dut.drop_cnt),        32'(stale_n));
            if (expq.size() > 0) begin
                check_eq("instr",    bus.instr,    expq[0].word);
                check_eq("instr_pc", bus.instr_pc, expq[0].pc);
            end
            if (bus.imem_rvalid)
                assert (dut.outstanding != 0) else $error("imem response with nothing outstanding");

            do_pop = expq.size() > 0 && bus.instr_ready;
            if (bus.redirect_valid) begin
                foreach (inflight[i]) inflight[i].stale = 1'b1;
                if (bus.imem_rvalid) void'(inflight.pop_front());
                expq.delete();
                model_pc = {bus.redirect_pc[31:2], 2'b00};
            end else begin
                if (do_pop) void'(expq.pop_front());
                if (bus.imem_rvalid) begin
                    f = inflight.pop_front();
                    if (!f.stale) expq.push_back('{pc: f.pc, word: bus.imem_rdata});
                end
                if (exp_req) begin
                    inflight.push_back('{pc: model_pc, stale: 1'b0, issue: cyc});
                    model_pc = model_pc + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        int unsigned n;
        rst = 1'b1;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b1;
        model_pc = RST_PC;

        // Reset, then 1-cycle memory with the consumer always ready.
        repeat (2) tick();
        rst_next = 1'b0;
        repeat (20) tick();

        // Backpressure: queue and credits fill, then drain on release.
        ready_pct = 0;
        repeat (10) tick();
        ready_pct = 100;
        repeat (10) tick();

        // 3-cycle memory, redirect with requests in flight.
        lat = 3;
        n = 0;
        while (inflight.size() < 3 && n < 20) begin tick(); n++; end
        check_eq("reach_3_outstanding", {31'b0, inflight.size() >= 3}, 32'h1);
        redir_now = 1'b1; redir_tgt = 32'h0000_0103;
        repeat (15) tick();

        // Redirect coinciding with a response and a pop.
        lat = 1;
        repeat (8) tick();
        n = 0;
        while (!(resp_due() && expq.size() > 0) && n < 20) begin tick(); n++; end
        check_eq("reach_rsp_pop", {31'b0, resp_due() && expq.size() > 0}, 32'h1);
        redir_now = 1'b1; redir_tgt = 32'h0000_0200;
        repeat (10) tick();

        // Address wrap at the top of the address space.
        redir_now = 1'b1; redir_tgt = 32'hFFFF_FFF8;
        repeat (12) tick();

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            if (k % 50 == 0) begin
                lat = $urandom_range(3, 1);
                ready_pct = $urandom_range(100, 30);
            end
            if ($urandom_range(99) < 3) begin
                redir_now = 1'b1;
                redir_tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                     : $urandom;
            end
            tick();
        end

        // Reset mid-stream with two queued and two outstanding.
        lat = 3; ready_pct = 0;
        redir_now = 1'b1; redir_tgt = 32'h0000_0400;
        tick();
        n = 0;
        while (!(expq.size() == 2 && inflight.size() == 2) && n < 30) begin tick(); n++; end
        check_eq("reach_2q_2o", {31'b0, expq.size() == 2 && inflight.size() == 2}, 32'h1);
        rst_next = 1'b1;
        repeat (2) tick();
        rst_next = 1'b0; ready_pct = 100; lat = 1;
        repeat (12) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
